// File: rtl/rtc_secuenciador_regs_if.sv
// rtc_secuenciador_regs_if: start/mode, bus-engine handshake and register-bank signals of the RTC scan sequencer
interface rtc_secuenciador_regs_if #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 7
);
  localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  logic                       iniciar;
  logic                       modo;
  logic                       fin;
  logic [DATA_W-1:0]          dato_rd;
  logic [NUM_REGS*DATA_W-1:0] datos_wr;
  logic [ADDR_W-1:0]          dir;
  logic [IDX_W-1:0]           dir_reg;
  logic [DATA_W-1:0]          dato;
  logic                       read;
  logic                       write;
  logic                       lectura;
  logic                       escritura;
  logic [NUM_REGS*DATA_W-1:0] datos_rd;
  logic                       final_pasada;
  logic                       error;
  modport master (
    output iniciar, modo, fin, dato_rd, datos_wr,
    input  dir, dir_reg, dato, read, write, lectura, escritura, datos_rd, final_pasada, error
  );
  modport slave (
    input  iniciar, modo, fin, dato_rd, datos_wr,
    output dir, dir_reg, dato, read, write, lectura, escritura, datos_rd, final_pasada, error
  );
endinterface

// File: rtl/rtc_secuenciador_regs.sv
// rtc_secuenciador_regs: scans NUM_REGS RTC registers per pass (read or write), one strobe/fin bus cycle each; ports clk, reset, bus (slave: iniciar/modo/fin/dato_rd/datos_wr in; dir/dir_reg/dato/read/write/lectura/escritura/datos_rd/final_pasada/error out); RTC_SEQ_TIMEOUT_EN adds a WAIT timeout
module rtc_secuenciador_regs #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 8,
  parameter int                NUM_REGS    = 7,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h21
`ifdef RTC_SEQ_TIMEOUT_EN
  ,
  parameter int                TIMEOUT_CYC = 16
`endif
) (
  input logic                      clk,
  input logic                      reset,
  rtc_secuenciador_regs_if.slave   bus
);
  localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t                     st;
  logic [IDX_W-1:0]           idx;
  logic [IDX_W-1:0]           nxt;
  logic                       modo_q;
  logic [NUM_REGS*DATA_W-1:0] snap;
`ifdef RTC_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
`endif
  assign nxt = idx + 1'b1;
  assign bus.dir_reg = idx;
  // Strobe, dir and dato are loaded on the edge that enters ISSUE so they are valid during ISSUE itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      st               <= IDLE;
      idx              <= '0;
      modo_q           <= 1'b0;
      snap             <= '0;
      bus.dir          <= '0;
      bus.dato         <= '0;
      bus.read         <= 1'b0;
      bus.write        <= 1'b0;
      bus.lectura      <= 1'b0;
      bus.escritura    <= 1'b0;
      bus.datos_rd     <= '0;
      bus.final_pasada <= 1'b0;
      bus.error        <= 1'b0;
`ifdef RTC_SEQ_TIMEOUT_EN
      cnt              <= '0;
`endif
    end else begin
      bus.read         <= 1'b0;
      bus.write        <= 1'b0;
      bus.final_pasada <= 1'b0;
      bus.error        <= 1'b0;
      case (st)
        IDLE, DONE: begin
          if (bus.iniciar) begin
            modo_q        <= bus.modo;
            snap          <= bus.datos_wr;
            idx           <= '0;
            bus.lectura   <= ~bus.modo;
            bus.escritura <= bus.modo;
            bus.read      <= ~bus.modo;
            bus.write     <= bus.modo;
            bus.dir       <= BASE_ADDR;
            bus.dato      <= bus.modo ? bus.datos_wr[DATA_W-1:0] : '0;
            st            <= ISSUE;
          end else begin
            bus.lectura   <= 1'b0;
            bus.escritura <= 1'b0;
            st            <= IDLE;
          end
        end
        ISSUE: begin
          st <= WAIT;
`ifdef RTC_SEQ_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        WAIT: begin
          if (bus.fin) begin
            if (!modo_q) bus.datos_rd[idx*DATA_W +: DATA_W] <= bus.dato_rd;
            if (idx == LAST) begin
              bus.final_pasada <= 1'b1;
              st               <= DONE;
            end else begin
              idx       <= nxt;
              bus.read  <= ~modo_q;
              bus.write <= modo_q;
              bus.dir   <= BASE_ADDR + ADDR_W'(nxt);
              bus.dato  <= modo_q ? snap[nxt*DATA_W +: DATA_W] : '0;
              st        <= ISSUE;
            end
          end
`ifdef RTC_SEQ_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            bus.error     <= 1'b1;
            bus.lectura   <= 1'b0;
            bus.escritura <= 1'b0;
            st            <= IDLE;
          end else cnt <= cnt + 1'b1;
`endif
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/rtc_secuenciador_regs.md
Name: rtc_secuenciador_regs

Overview:
Parametrised RTC register-scan sequencer, next generation of the single-pass read loop. On `iniciar` it runs one bus cycle per register over NUM_REGS consecutive RTC addresses, in read mode or write mode. Each cycle is a strobe to the lower-level bus-cycle engine plus a wait for its `fin` done pulse. Read data is buffered in a register bank and write data is snapshotted at pass start; holding `iniciar` high repeats passes back-to-back.

Parameters:
DATA_W, 8, data width of one RTC register
ADDR_W, 8, RTC address width
NUM_REGS, 7, registers per pass (>=1)
BASE_ADDR, 8'h21, address of register index 0
TIMEOUT_CYC, 16, cycles allowed in WAIT before abort (only with RTC_SEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
iniciar  in  1  start request, level-sampled in IDLE and DONE
modo  in  1  0 = read pass, 1 = write pass; latched at pass start
fin  in  1  bus-engine done pulse, honoured only in WAIT
dato_rd  in  DATA_W  read data from bus engine, valid when fin=1
datos_wr  in  NUM_REGS*DATA_W  write data, register i at bits [i*DATA_W +: DATA_W]
dir  out  ADDR_W  RTC address of current access
dir_reg  out  clog2(NUM_REGS) (min 1)  current register index
dato  out  DATA_W  write data for current access (0 in read mode)
read  out  1  one-cycle read strobe to bus engine
write  out  1  one-cycle write strobe to bus engine
lectura  out  1  high throughout a read pass
escritura  out  1  high throughout a write pass
datos_rd  out  NUM_REGS*DATA_W  buffered read results, same packing as datos_wr
final  out  1  one-cycle pulse when a pass completes
error  out  1  one-cycle timeout pulse (tied 0 without the macro)

Behaviour:
- Reset (synchronous, priority over everything):
  - State goes to IDLE and the index clears to 0.
  - All outputs go to 0, including datos_rd and the write snapshot.
  - Reset mid-pass aborts with no `final` pulse.
- All outputs are registered; FSM states are IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - With iniciar=1: latch modo, snapshot datos_wr, index=0, go to ISSUE.
  - lectura/escritura are set by the latched modo on that same edge.
- ISSUE (exactly 1 cycle):
  - read=1 if modo=0, write=1 if modo=1.
  - dir = BASE_ADDR + index, truncated to ADDR_W.
  - dato = snapshot[index] in write mode, else 0.
  - fin is ignored in this state.
  - Next state is WAIT.
- WAIT:
  - dir, dir_reg and dato hold; strobes are 0.
  - fin=1 in the first WAIT cycle is accepted.
  - On fin in read mode, datos_rd[index] <= dato_rd; other slices are unchanged.
  - If index == NUM_REGS-1, go to DONE; otherwise index+1, go to ISSUE.
- DONE (1 cycle):
  - final=1; lectura/escritura stay high this cycle.
  - If iniciar=1: re-latch modo, re-snapshot datos_wr, index=0, go to ISSUE.
  - Otherwise clear lectura/escritura and go to IDLE.
- Latency: iniciar sampled high → strobe for index 0 asserts on the next cycle; fin sampled → next strobe asserts on the next cycle.
- Deasserting iniciar mid-pass has no effect; the pass completes and no restart follows.
- Changing modo or datos_wr mid-pass does not affect the current pass.
- datos_rd keeps its last values across passes and write passes, until reset.

Optional Feature:
- Macro: RTC_SEQ_TIMEOUT_EN.
- When defined:
  - A WAIT-state counter counts cycles in WAIT and clears on entering WAIT.
  - If it reaches TIMEOUT_CYC without fin: error=1 for one cycle, no `final`, lectura/escritura clear, state returns to IDLE.
  - Partially captured datos_rd slices are kept.
- When undefined: no counter, error tied 0, WAIT waits indefinitely.

Test Plan:
- Read pass:
  - Stimulus: reset, then iniciar=1 for 1 cycle with modo=0; fin 3 cycles after each read strobe with dato_rd=8'h10+index.
  - Required: 7 read pulses at dir 8'h21..8'h27; datos_rd = {16,15,14,13,12,11,10}h; one final pulse after the 7th fin; lectura high throughout.
- Write pass:
  - Stimulus: modo=1, datos_wr slices 8'h59,8'h30,8'h12,8'h03,8'h14,8'h09,8'h16; change datos_wr to all 8'hFF after the 2nd strobe.
  - Required: dato shows the original values in order; 7 write pulses; datos_rd unchanged.
- Continuous mode:
  - Stimulus: iniciar held high for two passes with fin replies.
  - Required: final pulses twice; the index-0 strobe of pass 2 lands the cycle after DONE; iniciar dropped during pass 2 gives IDLE after its final.
- Handshake edges:
  - Stimulus: fin=1 during ISSUE and during IDLE; fin in the first WAIT cycle.
  - Required: ISSUE/IDLE fin is ignored (no index advance); first-WAIT fin is accepted.
- Reset mid-pass:
  - Stimulus: synchronous reset while in WAIT at index 3.
  - Required: next cycle all outputs 0, datos_rd cleared, no final, stays IDLE with iniciar=0.
- Timeout (RTC_SEQ_TIMEOUT_EN defined):
  - Stimulus: no fin after the index-2 strobe.
  - Required: error pulse after 16 WAIT cycles, no final, slices 0–1 retained, state IDLE.
